// File: rtl/montgomery_exp_ct.sv
// montgomery_exp_ct: modular exponentiator, result = x^e mod m (m odd), built on
// one bit-serial radix-2 Montgomery multiplier (WORD_WIDTH+1 cycles per product).
// mode 0 runs left-to-right square-and-multiply; mode 1 runs a Montgomery ladder
// that always issues two products per exponent bit.
// Ports:
//   clk, reset (async, active low)
//   start, mode, m, x, e, t, r2 : request and operands, latched when start is accepted in IDLE
//   busy   : high from the cycle after acceptance until the done cycle
//   done   : one-cycle completion pulse; error is valid alongside it
//   result : x^e mod m, held until the next completion
module montgomery_exp_ct #(
  parameter int WORD_WIDTH = 32,
  parameter int E_WIDTH    = 17,
  parameter int T_WIDTH    = $clog2(E_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] x,
  input  logic [E_WIDTH-1:0]    e,
  input  logic [T_WIDTH-1:0]    t,
  input  logic [WORD_WIDTH-1:0] r2,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] result
);

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int SW = WORD_WIDTH + 2;
  localparam logic [CW-1:0]         CNT_LAST = CW'(WORD_WIDTH);
  localparam logic [WORD_WIDTH-1:0] ONE_W    = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [T_WIDTH-1:0]    T_ZERO   = {T_WIDTH{1'b0}};
  localparam logic [T_WIDTH-1:0]    T_ONE    = {{(T_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0] DST_A  = 2'd0;
  localparam logic [1:0] DST_B  = 2'd1;
  localparam logic [1:0] DST_XM = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TO_MONT   = 3'd1,
    LOOP      = 3'd2,
    FROM_MONT = 3'd3,
    DONE_ST   = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic [WORD_WIDTH-1:0] m_r, x_r, r2_r, xm_r, a_r, b_r;
  logic [E_WIDTH-1:0]    e_r;
  logic [T_WIDTH-1:0]    t_r, idx_r;
  logic                  mode_r, err_r, sub_r;
  logic [CW-1:0]         cnt_r;
  logic [SW-1:0]         s_r;

  logic                  accept_s, bad_req_s, op_end_s, cur_bit_s, bit_last_s, abit_s;
  logic [WORD_WIDTH-1:0] op_a_s, op_b_s, fin_s;
  logic [1:0]            dst_s;
  logic [SW-1:0]         sum1_s, sum2_s, s_next_s;
  logic                  busy_s, done_s, error_s;
  logic [WORD_WIDTH-1:0] result_s;

  // Bit k of v; out-of-range k (the final-subtract cycle) yields 0.
  function automatic logic bit_at(input logic [WORD_WIDTH-1:0] v, input logic [CW-1:0] k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (k == CW'(i)) r = v[i];
      else             r = r;
    end
    return r;
  endfunction

  assign accept_s   = (state_r == IDLE) && start;
  assign bad_req_s  = ~m[0] || (t > T_WIDTH'(E_WIDTH));
  assign op_end_s   = (cnt_r == CNT_LAST);
  assign cur_bit_s  = e_r[idx_r];
  // A bit is finished after its second product, or after the square alone in mode 0 with e[i]=0.
  assign bit_last_s = sub_r || !(mode_r || cur_bit_s);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = bad_req_s ? DONE_ST : TO_MONT;
        else       state_s = IDLE;
      end
      TO_MONT: begin
        if (op_end_s && sub_r) state_s = (t_r == T_ZERO) ? FROM_MONT : LOOP;
        else                   state_s = TO_MONT;
      end
      LOOP: begin
        if (op_end_s && bit_last_s && (idx_r == T_ZERO)) state_s = FROM_MONT;
        else                                              state_s = LOOP;
      end
      FROM_MONT: begin
        if (op_end_s) state_s = DONE_ST;
        else          state_s = FROM_MONT;
      end
      DONE_ST: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output next values; busy follows the state being entered so it drops on the done edge.
  always_comb begin
    busy_s  = (state_s != IDLE);
    done_s  = (state_r == DONE_ST);
    error_s = (state_r == DONE_ST) && err_r;
    if (state_r == DONE_ST) result_s = err_r ? {WORD_WIDTH{1'b0}} : a_r;
    else                    result_s = result;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= {WORD_WIDTH{1'b0}};
    end else begin
      busy   <= busy_s;
      done   <= done_s;
      error  <= error_s;
      result <= result_s;
    end
  end

  // Operand and destination selection for the product currently in flight.
  always_comb begin
    op_a_s = {WORD_WIDTH{1'b0}};
    op_b_s = {WORD_WIDTH{1'b0}};
    dst_s  = DST_A;
    case (state_r)
      TO_MONT: begin
        if (!sub_r) begin op_a_s = x_r;   op_b_s = r2_r; dst_s = DST_XM; end
        else        begin op_a_s = ONE_W; op_b_s = r2_r; dst_s = DST_A;  end
      end
      LOOP: begin
        if (!mode_r) begin
          op_a_s = a_r;
          op_b_s = sub_r ? xm_r : a_r;
          dst_s  = DST_A;
        end else if (!sub_r) begin
          op_a_s = a_r; op_b_s = b_r;
          dst_s  = cur_bit_s ? DST_A : DST_B;
        end else if (cur_bit_s) begin
          op_a_s = b_r; op_b_s = b_r; dst_s = DST_B;
        end else begin
          op_a_s = a_r; op_b_s = a_r; dst_s = DST_A;
        end
      end
      FROM_MONT: begin op_a_s = a_r; op_b_s = ONE_W; dst_s = DST_A; end
      default:   begin op_a_s = {WORD_WIDTH{1'b0}}; op_b_s = {WORD_WIDTH{1'b0}}; dst_s = DST_A; end
    endcase
  end

  // One Montgomery iteration plus the final conditional subtract. S stays below b+m < 2m.
  always_comb begin
    abit_s = bit_at(op_a_s, cnt_r);
    if (abit_s) sum1_s = s_r + {2'b00, op_b_s};
    else        sum1_s = s_r;
    if (sum1_s[0]) sum2_s = sum1_s + {2'b00, m_r};
    else           sum2_s = sum1_s;
    s_next_s = {1'b0, sum2_s[SW-1:1]};
    if (s_r >= {2'b00, m_r}) fin_s = s_r[WORD_WIDTH-1:0] - m_r;
    else                     fin_s = s_r[WORD_WIDTH-1:0];
  end

  // Datapath: operand latch, multiplier accumulator and exponent-bit sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_r <= {WORD_WIDTH{1'b0}}; x_r <= {WORD_WIDTH{1'b0}}; r2_r <= {WORD_WIDTH{1'b0}};
      xm_r <= {WORD_WIDTH{1'b0}}; a_r <= {WORD_WIDTH{1'b0}}; b_r <= {WORD_WIDTH{1'b0}};
      e_r <= {E_WIDTH{1'b0}}; t_r <= T_ZERO; idx_r <= T_ZERO;
      mode_r <= 1'b0; err_r <= 1'b0; sub_r <= 1'b0;
      cnt_r <= {CW{1'b0}}; s_r <= {SW{1'b0}};
    end else if (accept_s) begin
      m_r <= m; x_r <= x; r2_r <= r2; e_r <= e; t_r <= t; mode_r <= mode;
      err_r <= bad_req_s; sub_r <= 1'b0; cnt_r <= {CW{1'b0}}; s_r <= {SW{1'b0}};
    end else if ((state_r == TO_MONT) || (state_r == LOOP) || (state_r == FROM_MONT)) begin
      if (op_end_s) begin
        case (dst_s)
          DST_A:   a_r <= fin_s;
          DST_B:   b_r <= fin_s;
          DST_XM:  begin xm_r <= fin_s; b_r <= fin_s; end
          default: a_r <= fin_s;
        endcase
        cnt_r <= {CW{1'b0}};
        s_r   <= {SW{1'b0}};
        case (state_r)
          TO_MONT: begin
            sub_r <= ~sub_r;
            if (sub_r) idx_r <= t_r - T_ONE;
            else       idx_r <= idx_r;
          end
          LOOP: begin
            if (bit_last_s) begin sub_r <= 1'b0; idx_r <= idx_r - T_ONE; end
            else            begin sub_r <= 1'b1; idx_r <= idx_r; end
          end
          default: sub_r <= 1'b0;
        endcase
      end else begin
        s_r   <= s_next_s;
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_montgomery_exp_ct.sv
module tb_montgomery_exp_ct;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic [31:0] m = 32'd0, x = 32'd0, r2 = 32'd0;
  logic [16:0] e = 17'd0;
  logic [4:0]  t = 5'd0;
  logic        busy, done, error;
  logic [31:0] result;

  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;

  montgomery_exp_ct #(.WORD_WIDTH(32), .E_WIDTH(17)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .m(m), .x(x), .e(e),
    .t(t), .r2(r2), .busy(busy), .done(done), .error(error), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] calc_r2(input logic [31:0] mm);
    longint unsigned r;
    r = (64'd1 << 32) % {32'd0, mm};
    return 32'((r * r) % {32'd0, mm});
  endfunction

  // Reference: plain modular arithmetic on 64-bit integers.
  function automatic logic [31:0] ref_exp(input logic [31:0] mm, input logic [31:0] xx,
                                          input logic [16:0] ee, input int tt);
    longint unsigned mod, b, r;
    mod = {32'd0, mm};
    b = {32'd0, xx} % mod;
    r = 64'd1 % mod;
    for (int i = tt - 1; i >= 0; i--) begin
      r = (r * r) % mod;
      if (ee[i]) r = (r * b) % mod;
    end
    return 32'(r);
  endfunction

  function automatic int ref_lat(input logic md, input logic [16:0] ee, input int tt);
    int n;
    n = 0;
    for (int i = 0; i < tt; i++) n += int'(ee[i]);
    if (md) return (2 * tt + 3) * 33 + 1;
    return (tt + n + 3) * 33 + 1;
  endfunction

  task automatic kick(input logic md, input logic [31:0] mm, input logic [31:0] xx,
                      input logic [16:0] ee, input logic [4:0] tt);
    @(negedge clk);
    mode = md; m = mm; x = xx; e = ee; t = tt; r2 = calc_r2(mm); start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    while (!done && (cyc - t0) < 5000) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - t0;
  endtask

  task automatic run_check(input string tag, input logic md, input logic [31:0] mm,
                           input logic [31:0] xx, input logic [16:0] ee, input logic [4:0] tt,
                           output logic [31:0] res, output int lat);
    logic        exp_err;
    logic [31:0] exp_res;
    int          exp_lat;
    kick(md, mm, xx, ee, tt);
    wait_done(lat);
    res = result;
    exp_err = (mm[0] == 1'b0) || (tt > 5'd17);
    if (exp_err) begin
      exp_res = 32'd0; exp_lat = 1;
    end else begin
      exp_res = ref_exp(mm, xx, ee, int'(tt)); exp_lat = ref_lat(md, ee, int'(tt));
    end
    chk({tag, "_lat"}, longint'(lat), longint'(exp_lat));
    chk({tag, "_res"}, {32'd0, result}, {32'd0, exp_res});
    chk({tag, "_err"}, {63'd0, error}, {63'd0, exp_err});
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] res, res2;
    int          lat, lat2;
    logic        saw_done;
    logic [31:0] rm, rx;
    logic [16:0] re;
    logic [4:0]  rt;
    logic        rmd;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, error}, 64'd0);
    chk("rst_res", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic vectors from the plan.
    run_check("basic_m0", 1'b0, 32'd497, 32'd4, 17'd13, 5'd4, res, lat);
    chk("basic_m0_445", {32'd0, res}, 64'd445);
    chk("basic_m0_331", longint'(lat), 64'd331);
    run_check("basic_m1", 1'b1, 32'd497, 32'd4, 17'd13, 5'd4, res, lat);
    chk("basic_m1_445", {32'd0, res}, 64'd445);
    chk("basic_m1_364", longint'(lat), 64'd364);

    // Fermat.
    run_check("fermat_m0", 1'b0, 32'd65537, 32'd2, 17'd65536, 5'd17, res, lat);
    chk("fermat_m0_one", {32'd0, res}, 64'd1);
    run_check("fermat_m1", 1'b1, 32'd65537, 32'd2, 17'd65536, 5'd17, res, lat);
    chk("fermat_m1_one", {32'd0, res}, 64'd1);

    // Boundaries.
    run_check("bigm", 1'b1, 32'd4294967291, 32'd4294967290, 17'd2, 5'd2, res, lat);
    chk("bigm_one", {32'd0, res}, 64'd1);
    run_check("t0_m0", 1'b0, 32'd497, 32'd123, 17'd5, 5'd0, res, lat);
    chk("t0_m0_one", {32'd0, res}, 64'd1);
    run_check("t0_m1", 1'b1, 32'd497, 32'd123, 17'd5, 5'd0, res, lat);
    chk("t0_m1_one", {32'd0, res}, 64'd1);
    run_check("m1", 1'b0, 32'd1, 32'd9, 17'd7, 5'd3, res, lat);
    chk("m1_zero", {32'd0, res}, 64'd0);
    run_check("xbig", 1'b1, 32'd497, 32'd502, 17'd1, 5'd1, res, lat);
    chk("xbig_five", {32'd0, res}, 64'd5);

    // Ladder timing independent of e.
    run_check("ct_e00", 1'b1, 32'd1000003, 32'd77, 17'h00, 5'd8, res, lat);
    run_check("ct_eff", 1'b1, 32'd1000003, 32'd77, 17'hFF, 5'd8, res2, lat2);
    chk("ct_equal", longint'(lat), longint'(lat2));
    chk("ct_628", longint'(lat2), 64'd628);

    // Errors (previous result is nonzero, so result=0 is observable).
    run_check("err_even", 1'b0, 32'd496, 32'd4, 17'd13, 5'd4, res, lat);
    chk("err_even_lat1", longint'(lat), 64'd1);
    run_check("basic_again", 1'b0, 32'd497, 32'd4, 17'd13, 5'd4, res, lat);
    run_check("err_t18", 1'b1, 32'd497, 32'd4, 17'd13, 5'd18, res, lat);
    chk("err_t18_flag", {63'd0, error}, 64'd1);

    // Start pulse with different operands while busy must be ignored.
    kick(1'b1, 32'd497, 32'd4, 17'd13, 5'd4);
    repeat (40) @(posedge clk);
    @(negedge clk);
    mode = 1'b0; m = 32'd1001; x = 32'd7; e = 17'd3; t = 5'd2; r2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("midstart_res", {32'd0, result}, 64'd445);
    chk("midstart_lat", longint'(lat), 64'd364);

    // Reset at cycle 100 of an operation.
    kick(1'b0, 32'd497, 32'd4, 17'd13, 5'd4);
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_err", {63'd0, error}, 64'd0);
    chk("abort_res", {32'd0, result}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {63'd0, saw_done}, 64'd0);
    run_check("after_abort", 1'b0, 32'd497, 32'd4, 17'd13, 5'd4, res, lat);
    chk("after_abort_445", {32'd0, res}, 64'd445);

    // Randomised vectors against the reference.
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) rm = 32'($urandom_range(1, 2000)) | 32'd1;
      else            rm = $urandom | 32'd1;
      rx  = $urandom;
      re  = 17'($urandom_range(0, 131071));
      rt  = 5'($urandom_range(0, 17));
      rmd = 1'($urandom_range(0, 1));
      run_check($sformatf("rand%0d", i), rmd, rm, rx, re, rt, res, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
